// File: rtl/pu_local_buffer.sv
// Frame-grouping result buffer behind the PU control stage: captures result words,
// commits them as frames on MAC-done, and streams committed frames with a last marker.
module pu_local_buffer #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_terminate,
  input  logic                  i_en,
  input  logic                  i_wr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_frame_done,
  output logic                  o_m_valid,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic                  o_m_last,
  input  logic                  i_m_ready,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_overflow
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      last_flag;
  logic [ADDR_WIDTH:0]   wr_ptr, cm_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   wr_next, last_ptr;
  logic                  overflow;
  logic                  wr_fire, wr_drop, commit, rd_fire;

  assign o_count   = wr_ptr - rd_ptr;
  assign o_full    = (o_count == (ADDR_WIDTH+1)'(DEPTH));
  assign o_empty   = (o_count == '0);
  assign o_m_valid = (rd_ptr != cm_ptr);
  assign o_m_data  = o_m_valid ? mem[rd_ptr[ADDR_WIDTH-1:0]] : '0;
  assign o_m_last  = o_m_valid & last_flag[rd_ptr[ADDR_WIDTH-1:0]];
  assign o_overflow = overflow;

  assign wr_fire  = i_en & i_wr & ~o_full;
  assign wr_drop  = i_en & i_wr & o_full;
  assign wr_next  = wr_ptr + {{ADDR_WIDTH{1'b0}}, wr_fire};
  assign last_ptr = wr_next - (ADDR_WIDTH+1)'(1);
  // A word written alongside MAC-done joins the frame being closed, so compare
  // against the post-write pointer; an empty frame never commits.
  assign commit   = i_frame_done & (wr_next != cm_ptr);
  assign rd_fire  = o_m_valid & i_m_ready;

  // Control state: pointers, last flags, sticky overflow
  always_ff @(posedge i_clk) begin
    if (i_reset || i_terminate) begin
      wr_ptr    <= '0;
      cm_ptr    <= '0;
      rd_ptr    <= '0;
      last_flag <= '0;
      overflow  <= 1'b0;
    end else begin
      if (wr_fire) begin
        wr_ptr                               <= wr_next;
        last_flag[wr_ptr[ADDR_WIDTH-1:0]]    <= 1'b0;
      end
      if (wr_drop)
        overflow <= 1'b1;
      // Placed after the write clear so a same-cycle commit marks the new word.
      if (commit) begin
        cm_ptr                               <= wr_next;
        last_flag[last_ptr[ADDR_WIDTH-1:0]]  <= 1'b1;
      end
      if (rd_fire)
        rd_ptr <= rd_ptr + (ADDR_WIDTH+1)'(1);
    end
  end

  // Data storage is not reset; outputs mask stale contents via o_m_valid
  always_ff @(posedge i_clk) begin
    if (wr_fire)
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= i_data;
  end

endmodule

// File: tb/tb_pu_local_buffer.sv
// Directed bench for pu_local_buffer: reset, framing, overflow, backpressure,
// concurrent write/read/commit, wrap-around and mid-drain terminate.
module tb_pu_local_buffer;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset, terminate, en, wr, frame_done, m_ready;
  logic [DW-1:0] data;
  logic          m_valid, m_last, full, empty, overflow;
  logic [DW-1:0] m_data;
  logic [AW:0]   count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pu_local_buffer #(.DATA_WIDTH(DW), .DEPTH(16)) dut (
    .i_clk(clk), .i_reset(reset), .i_terminate(terminate),
    .i_en(en), .i_wr(wr), .i_data(data), .i_frame_done(frame_done),
    .o_m_valid(m_valid), .o_m_data(m_data), .o_m_last(m_last),
    .i_m_ready(m_ready), .o_count(count), .o_full(full),
    .o_empty(empty), .o_overflow(overflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [DW-1:0] w, input logic done);
    en = 1'b1; wr = 1'b1; data = w; frame_done = done;
    step();
    en = 1'b0; wr = 1'b0; frame_done = 1'b0;
  endtask

  task automatic commit_frame();
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
  endtask

  // Caller holds m_ready=1; checks the current beat then advances one cycle
  task automatic beat(input string tag, input logic [DW-1:0] w, input logic l);
    chk({tag, "_valid"}, m_valid, 1'b1);
    chk({tag, "_data"}, m_data, w);
    chk({tag, "_last"}, m_last, l);
    step();
  endtask

  initial begin
    reset = 1'b1; terminate = 1'b0; en = 1'b0; wr = 1'b0;
    data = '0; frame_done = 1'b0; m_ready = 1'b0;
    step();
    reset = 1'b0;
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_data", m_data, 32'h0);
    chk("rst_last", m_last, 1'b0);
    chk("rst_count", count, 5'd0);
    chk("rst_full", full, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_overflow", overflow, 1'b0);
    commit_frame();
    chk("empty_commit_valid", m_valid, 1'b0);
    step();
    chk("empty_commit_valid2", m_valid, 1'b0);

    // Single frame of four words
    for (int i = 0; i < 4; i++) write_word(32'h11 + i, 1'b0);
    chk("single_count", count, 5'd4);
    chk("single_hidden", m_valid, 1'b0);
    commit_frame();
    chk("single_visible", m_valid, 1'b1);
    chk("single_first", m_data, 32'h11);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) beat("single", 32'h11 + i, i == 3);
    m_ready = 1'b0;
    chk("single_empty", empty, 1'b1);
    chk("single_done_valid", m_valid, 1'b0);

    // Overflow: 17 writes into 16 entries
    for (int i = 0; i < 17; i++) write_word(i, 1'b0);
    chk("ovf_full", full, 1'b1);
    chk("ovf_count", count, 5'd16);
    chk("ovf_flag", overflow, 1'b1);
    commit_frame();
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) beat("ovf", i, i == 15);
    m_ready = 1'b0;
    chk("ovf_drained", empty, 1'b1);
    chk("ovf_sticky", overflow, 1'b1);

    // Backpressure, simultaneous write/read, write with commit
    for (int i = 0; i < 5; i++) write_word(32'h30 + i, 1'b0);
    commit_frame();
    for (int i = 0; i < 5; i++) begin
      chk("bp_data", m_data, 32'h30);
      chk("bp_last", m_last, 1'b0);
      step();
    end
    chk("bp_count", count, 5'd5);
    m_ready = 1'b1;
    write_word(32'h35, 1'b0);
    m_ready = 1'b0;
    chk("wr_rd_count", count, 5'd5);
    chk("wr_rd_data", m_data, 32'h31);
    write_word(32'h36, 1'b1);
    chk("wr_commit_count", count, 5'd6);
    m_ready = 1'b1;
    for (int i = 1; i < 7; i++) beat("bp", 32'h30 + i, (i == 4) || (i == 6));
    m_ready = 1'b0;
    chk("bp_empty", empty, 1'b1);
    chk("bp_ovf_sticky", overflow, 1'b1);

    // Wrap-around with two 12-word frames
    for (int f = 1; f <= 2; f++) begin
      for (int i = 0; i < 12; i++) write_word(32'h100 * f + i, 1'b0);
      commit_frame();
      m_ready = 1'b1;
      for (int i = 0; i < 12; i++) beat("wrap", 32'h100 * f + i, i == 11);
      m_ready = 1'b0;
      chk("wrap_empty", empty, 1'b1);
    end

    // Terminate after two of four beats
    for (int i = 0; i < 4; i++) write_word(32'h40 + i, 1'b0);
    commit_frame();
    m_ready = 1'b1;
    beat("term", 32'h40, 1'b0);
    beat("term", 32'h41, 1'b0);
    m_ready = 1'b0;
    terminate = 1'b1;
    step();
    terminate = 1'b0;
    chk("term_valid", m_valid, 1'b0);
    chk("term_data", m_data, 32'h0);
    chk("term_count", count, 5'd0);
    chk("term_overflow", overflow, 1'b0);
    chk("term_empty", empty, 1'b1);
    write_word(32'h55, 1'b0);
    chk("post_hidden", m_valid, 1'b0);
    commit_frame();
    m_ready = 1'b1;
    beat("post", 32'h55, 1'b1);
    m_ready = 1'b0;
    chk("post_empty", empty, 1'b1);
    chk("post_valid", m_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pu_local_buffer.md
# pu_local_buffer

Result buffer directly downstream of the PU control stage. It captures PU result words while the local-buffer enable and write strobes are high, and groups them into frames closed by the MAC-done pulse. Committed frames are streamed out on a valid/ready interface with a last marker on each frame's final word. Words of an open (uncommitted) frame are never visible downstream.

## Interface
- DATA_WIDTH, 32, result word width
- DEPTH, 16, entries; power of two, at least 2
- ADDR_WIDTH, log2(DEPTH), derived; not overridden
- i_clk  in  1  clock; all logic on rising edge
- i_reset  in  1  reset; one clock, synchronous, active-high
- i_terminate  in  1  flush; synchronous; same effect as reset
- i_en  in  1  local-buffer enable from PU control
- i_wr  in  1  local-buffer write strobe from PU control
- i_data  in  DATA_WIDTH  PU result word
- i_frame_done  in  1  MAC-done pulse; closes the open frame
- o_m_valid  out  1  committed word available
- o_m_data  out  DATA_WIDTH  word at read pointer; 0 when o_m_valid=0
- o_m_last  out  1  final word of a frame; 0 when o_m_valid=0
- i_m_ready  in  1  downstream accepts
- o_count  out  ADDR_WIDTH+1  stored words, committed plus open
- o_full  out  1  o_count==DEPTH
- o_empty  out  1  o_count==0
- o_overflow  out  1  sticky: a write was dropped

## Operation
- Storage is a circular register array mem[DEPTH] with a last-flag bit per entry.
- Pointers wr_ptr, cm_ptr and rd_ptr are each ADDR_WIDTH+1 bits. The MSB distinguishes full from empty.
- o_count = wr_ptr - rd_ptr, modulo 2^(ADDR_WIDTH+1).
- Write: when i_en & i_wr & !o_full:
  - mem[wr_ptr] <= i_data
  - last[wr_ptr] <= 0
  - wr_ptr++
- Dropped write: i_en & i_wr & o_full. The word is discarded, pointers are unchanged and o_overflow <= 1.
- Commit: on i_frame_done with wr_ptr != cm_ptr:
  - last[wr_ptr-1] <= 1
  - cm_ptr <= wr_ptr
- Empty commit: i_frame_done with wr_ptr == cm_ptr is a no-op. No empty frames are produced.
- Write and commit in the same cycle: the word written that cycle belongs to the frame being committed. It receives last=1 and cm_ptr <= wr_ptr+1.
- Drain:
  - o_m_valid = (rd_ptr != cm_ptr)
  - o_m_data = mem[rd_ptr]
  - o_m_last = last[rd_ptr]
  - On o_m_valid & i_m_ready: rd_ptr++.
- Write and read in the same cycle: both happen and o_count is unchanged. Full is evaluated before the read, so a write at full is dropped even if a read occurs that cycle.
- Wrap-around: pointers wrap naturally modulo 2^(ADDR_WIDTH+1), and the array index is ptr[ADDR_WIDTH-1:0]. Order is preserved across the wrap.
- Priority: i_reset > i_terminate > normal operation.
- Reset or terminate clears:
  - all pointers
  - all last flags
  - o_overflow
- Reset or terminate does not clear data contents. The outputs mask them.

## Timing
- Reset values: o_m_valid=0, o_m_data=0, o_m_last=0, o_count=0, o_full=0, o_empty=1, o_overflow=0.
- Write-to-count latency: 1 cycle. o_count reflects a write on the cycle after the edge that samples it.
- Commit-to-visible latency: 1 cycle. o_m_valid rises the cycle after i_frame_done is sampled.
- Outputs are combinational from registered pointers and the array. There are no combinational paths from any input to any output.
- Holding rule: while o_m_valid=1 and i_m_ready=0, o_m_data and o_m_last stay stable.
- Throughput: 1 word/cycle on the write side and on the read side simultaneously.
- Mid-operation terminate or reset:
  - The next cycle shows reset values.
  - Any open frame and any committed frames are discarded.
  - A partially drained frame is abandoned and never resumed.
- o_overflow stays high until reset or terminate.

## Test plan
- Reset with DEPTH=16: assert i_reset for 1 cycle, then check all outputs at their reset values. Pulse i_frame_done with no writes and check o_m_valid stays 0.
- Single frame:
  - Write 0x11, 0x12, 0x13, 0x14 on consecutive cycles. Check o_count=4 and o_m_valid=0.
  - Pulse i_frame_done and check o_m_valid=1 next cycle with data 0x11.
  - Hold i_m_ready=1 and check four beats with o_m_last=1 only on 0x14, then o_empty=1.
- Overflow:
  - Write 17 words 0x00 to 0x10 and check o_full=1 and o_overflow=1.
  - Commit, then check the drain yields exactly 0x00 to 0x0F with last on 0x0F.
  - Check o_overflow stays 1 until terminate.
- Backpressure and concurrency:
  - Hold i_m_ready=0 for 5 cycles and check data stays stable.
  - With o_count=5, write and read in the same cycle and check o_count stays 5.
  - Write a word in the same cycle as i_frame_done and check that word carries last=1.
- Wrap-around: send two 12-word frames (0x100 to 0x10B, then 0x200 to 0x20B), draining the first before the second is written. Check order is preserved and last appears on 0x10B and on 0x20B.
- Terminate mid-drain:
  - After 2 of 4 beats, assert i_terminate. Check that next cycle o_m_valid=0, o_count=0 and o_overflow=0.
  - Then write 0x55 and commit, and check that the new frame outputs 0x55 with last=1.
